// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// ----------------
// Self-timed SPI transfer unit. It serialises a parallel word onto MOSI and
// gathers MISO into a right-aligned parallel word. It generates SCLK from
// i_clk with a fixed divider, drives chip select, and provides a start/done
// handshake. The transfer length, CPOL, CPHA and (optionally) bit order are
// chosen per transfer.
//
// Optional feature macro: SPI_SHIFT_LSB_FIRST_EN
//   defined   : i_lsb_first selects LSB-first or MSB-first per transfer
//   undefined : every transfer is MSB-first and i_lsb_first is ignored
//
// Parameters
//   WIDTH    maximum transfer length in bits (>= 2)
//   CLK_DIV  i_clk cycles per SCLK half-period (>= 1)
//   LW       width of i_len (derived)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      transfer request, accepted only when idle
//   i_data_tx    word to send, sampled on accept
//   i_len        bit count; 0 or > WIDTH means WIDTH; sampled on accept
//   i_cpol       SCLK idle level
//   i_cpha       0: sample on leading edge, 1: sample on trailing edge
//   i_lsb_first  bit order (only with SPI_SHIFT_LSB_FIRST_EN)
//   i_miso       serial input
//   o_sclk       SPI clock
//   o_mosi       serial output, holds its last value between transfers
//   o_cs_n       chip select, active low
//   o_busy       transfer in progress (cycle after accept up to, not incl., done)
//   o_done       one-cycle end-of-transfer pulse
//   o_data_rx    received word, right-aligned, valid from o_done onwards
module spi_shift_engine #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4,
  parameter int LW      = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data_tx,
  input  logic [LW-1:0]    i_len,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic             i_lsb_first,
  input  logic             i_miso,
  output logic             o_sclk,
  output logic             o_mosi,
  output logic             o_cs_n,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data_rx
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]       state_reg;
  logic [DW-1:0]    div_reg;
  logic [LW:0]      edge_reg;     // index of the next SCLK edge
  logic [LW-1:0]    len_reg;
  logic [WIDTH-1:0] tx_sr;        // current bit at MSB (MSB-first) or LSB (LSB-first)
  logic [WIDTH-1:0] rx_sr;
  logic             cpol_reg;
  logic             cpha_reg;
  logic             lsb_mode;     // bit order of the transfer in flight
  logic             lsb_now;      // bit order requested at the input

  logic             tick;
  logic [LW:0]      last_idx;
  logic             last_edge;
  logic             leading;
  logic             do_sample;
  logic             do_advance;
  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] tx_aligned;
  logic             first_bit;

  // Half-period strobe: last cycle of each divider period.
  assign tick      = (div_reg == DW'(CLK_DIV - 1));
  assign last_idx  = {len_reg, 1'b0} - (LW + 1)'(1);
  assign last_edge = (edge_reg == last_idx);
  assign leading   = ~edge_reg[0];

  // CPHA=0 samples leading edges and moves MOSI on trailing edges (never
  // after the final one). CPHA=1 moves MOSI on leading edges except the
  // first, since the first bit is already presented during setup.
  assign do_sample  = cpha_reg ? ~leading : leading;
  assign do_advance = cpha_reg ? (leading && (edge_reg != '0))
                               : (!leading && !last_edge);

`ifdef SPI_SHIFT_LSB_FIRST_EN
  assign lsb_now = i_lsb_first;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lsb_mode <= 1'b0;
    end else if ((state_reg == ST_IDLE) && i_start) begin
      lsb_mode <= i_lsb_first;
    end
  end
`else
  logic lsb_unused;
  assign lsb_unused = i_lsb_first;
  assign lsb_now    = 1'b0;
  assign lsb_mode   = 1'b0;
`endif

  // Accept-time preparation: normalise the length and, for MSB-first, push
  // the word up so bit len-1 sits at the top of the shift register.
  always_comb begin
    eff_len = i_len;
    if ((i_len == '0) || (i_len > LW'(WIDTH))) begin
      eff_len = LW'(WIDTH);
    end
    tx_aligned = i_data_tx;
    if (!lsb_now) begin
      tx_aligned = i_data_tx << (WIDTH - int'(eff_len));
    end
    first_bit = lsb_now ? i_data_tx[0] : tx_aligned[WIDTH-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      edge_reg  <= '0;
      len_reg   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_cs_n    <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_data_rx <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          div_reg  <= '0;
          edge_reg <= '0;
          o_sclk   <= i_cpol;
          o_cs_n   <= 1'b1;
          if (i_start) begin
            state_reg <= ST_SETUP;
            len_reg   <= eff_len;
            cpol_reg  <= i_cpol;
            cpha_reg  <= i_cpha;
            tx_sr     <= tx_aligned;
            rx_sr     <= '0;
            o_mosi    <= first_bit;
            o_cs_n    <= 1'b0;
            o_busy    <= 1'b1;
          end
        end

        // The tick that ends setup produces SCLK edge 0, so setup and shift
        // share the edge handling; the edge counter tells them apart.
        ST_SETUP, ST_SHIFT: begin
          div_reg <= tick ? '0 : div_reg + DW'(1);
          if (tick) begin
            o_sclk   <= ~o_sclk;
            edge_reg <= edge_reg + (LW + 1)'(1);
            if (do_sample) begin
              rx_sr <= lsb_mode ? {i_miso, rx_sr[WIDTH-1:1]}
                                : {rx_sr[WIDTH-2:0], i_miso};
            end
            if (do_advance) begin
              if (lsb_mode) begin
                o_mosi <= tx_sr[1];
                tx_sr  <= tx_sr >> 1;
              end else begin
                o_mosi <= tx_sr[WIDTH-2];
                tx_sr  <= tx_sr << 1;
              end
            end
            state_reg <= last_edge ? ST_HOLD : ST_SHIFT;
          end
        end

        ST_HOLD: begin
          div_reg <= tick ? '0 : div_reg + DW'(1);
          o_sclk  <= cpol_reg;
          if (tick) begin
            state_reg <= ST_IDLE;
            o_cs_n    <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            // LSB-first bits entered at the top; slide them down to bit 0.
            o_data_rx <= lsb_mode ? (rx_sr >> (WIDTH - int'(len_reg))) : rx_sr;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;
  localparam int W     = 16;
  localparam int DIV   = 2;
  localparam int LW    = $clog2(W + 1);
  localparam int LIMIT = 2 * DIV * (2 * W + 1) + 20;
`ifdef SPI_SHIFT_LSB_FIRST_EN
  localparam bit LSB_EN = 1'b1;
`else
  localparam bit LSB_EN = 1'b0;
`endif

  typedef struct {
    bit [31:0] tx;
    bit [31:0] sw;     // word the slave shifts out
    int        len;    // raw i_len value
    int        n;      // effective length
    bit        cpol;
    bit        cpha;
    bit        lsb;
    bit        lsb_eff;
    bit        loop;   // MISO tied to MOSI
    bit        b2b;    // accepted in the previous done cycle
  } xfer_t;

  typedef struct {
    int        edges;
    bit [31:0] cap;    // word assembled by the slave from MOSI
  } sres_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  data_tx;
  logic [LW-1:0] len;
  logic          cpol;
  logic          cpha;
  logic          lsb_first;
  logic          miso;
  logic          o_sclk;
  logic          o_mosi;
  logic          o_cs_n;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_data_rx;

  xfer_t exp_q[$];
  xfer_t cfg_q[$];
  sres_t res_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int busy_rise = 0;
  int last_done = 0;
  bit prev_busy = 1'b0;

  logic slave_miso = 1'b0;
  bit   loop_mode  = 1'b0;
  int   s_edges    = 0;

  assign miso = loop_mode ? o_mosi : slave_miso;

  spi_shift_engine #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_data_tx   (data_tx),
    .i_len       (len),
    .i_cpol      (cpol),
    .i_cpha      (cpha),
    .i_lsb_first (lsb_first),
    .i_miso      (miso),
    .o_sclk      (o_sclk),
    .o_mosi      (o_mosi),
    .o_cs_n      (o_cs_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_data_rx   (o_data_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic xfer_t mk(input bit [31:0] tx, input bit [31:0] sw, input int l,
                               input bit cp, input bit ch, input bit lsb, input bit lp);
    xfer_t c;
    c.tx      = tx & 32'h0000_FFFF;
    c.sw      = sw & 32'h0000_FFFF;
    c.len     = l;
    c.n       = (l == 0 || l > W) ? W : l;
    c.cpol    = cp;
    c.cpha    = ch;
    c.lsb     = lsb;
    c.lsb_eff = lsb & LSB_EN;
    c.loop    = lp;
    c.b2b     = 1'b0;
    return c;
  endfunction

  function automatic bit [31:0] mask_of(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // i-th bit on the wire for the slave word
  function automatic bit sbit(input xfer_t c, input int i);
    if (i >= c.n) return 1'b0;
    return c.lsb_eff ? c.sw[i] : c.sw[c.n - 1 - i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Slave device: follows SCLK, shifts its word out and assembles MOSI.
  initial begin : slave
    xfer_t cur;
    sres_t r;
    int    idx;
    int    k;
    int    pos;
    bit    lead;
    forever begin
      @(negedge o_cs_n);
      if (cfg_q.size() > 0) cur = cfg_q.pop_front();
      else cur = mk(0, 0, W, 1'b0, 1'b0, 1'b0, 1'b0);
      loop_mode = cur.loop;
      s_edges   = 0;
      r.cap     = 0;
      idx       = 0;
      if (!cur.cpha) begin
        slave_miso = sbit(cur, 0);
        idx = 1;
      end
      forever begin
        @(o_sclk or posedge o_cs_n);
        if (o_cs_n) break;
        #1;
        if (o_cs_n) break;
        lead = (s_edges % 2) == 0;
        if (lead ^ cur.cpha) begin
          k = s_edges / 2;
          if (k < cur.n) begin
            pos = cur.lsb_eff ? k : cur.n - 1 - k;
            r.cap[pos] = o_mosi;
          end
        end else begin
          slave_miso = sbit(cur, idx);
          idx++;
        end
        s_edges++;
      end
      r.edges = s_edges;
      res_q.push_back(r);
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin : monitor
    xfer_t e;
    sres_t r;
    bit [31:0] m;
    forever begin
      @(negedge clk);
      if (o_busy && !prev_busy) busy_rise = cycle;
      prev_busy = o_busy;
      if (o_done) begin
        if (exp_q.size() == 0 || res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with %0d pending, want no done",
                   exp_q.size());
        end else begin
          e = exp_q.pop_front();
          r = res_q.pop_front();
          m = mask_of(e.n);
          chk("rx_word", 32'(o_data_rx), e.loop ? (e.tx & m) : (e.sw & m));
          chk("mosi_seq", r.cap, e.tx & m);
          chk("sclk_edges", 32'(r.edges), 32'(2 * e.n));
          chk("done_latency", 32'(cycle - busy_rise), 32'(DIV * (2 * e.n + 1)));
          chk("cs_n_at_done", 32'(o_cs_n), 32'd1);
          chk("busy_at_done", 32'(o_busy), 32'd0);
          chk("sclk_idle_after", 32'(o_sclk), 32'(e.cpol));
          if (e.b2b) chk("b2b_period", 32'(cycle - last_done), 32'(DIV * (2 * e.n + 1) + 1));
          $display("xfer len=%0d n=%0d cpol=%0d cpha=%0d lsb=%0d loop=%0d tx=0x%0h rx=0x%0h",
                   e.len, e.n, e.cpol, e.cpha, e.lsb_eff, e.loop, e.tx, o_data_rx);
          last_done = cycle;
        end
      end
    end
  end

  task automatic drive(input xfer_t c);
    @(negedge clk);
    data_tx   = c.tx[W-1:0];
    len       = c.len[LW-1:0];
    cpol      = c.cpol;
    cpha      = c.cpha;
    lsb_first = c.lsb;
    repeat (2) @(negedge clk);
    chk("sclk_idle_before", 32'(o_sclk), 32'(c.cpol));
  endtask

  task automatic push(input xfer_t c);
    exp_q.push_back(c);
    cfg_q.push_back(c);
  endtask

  task automatic launch(input xfer_t c);
    drive(c);
    push(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 32'(o_busy), 32'd1);
    chk("accept_cs_n", 32'(o_cs_n), 32'd0);
    // Inputs wander mid-transfer; the transfer must not notice.
    data_tx   = W'($urandom);
    len       = LW'($urandom);
    cpol      = 1'($urandom);
    cpha      = 1'($urandom);
    lsb_first = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!o_done && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (!o_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no done after %0d cycles, want done", name, k);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    xfer_t c;
    xfer_t c2;
    int    k;
    rst_n = 1'b1; start = 1'b0; data_tx = '0; len = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(o_sclk), 32'd0);
    chk("rst_mosi", 32'(o_mosi), 32'd0);
    chk("rst_cs_n", 32'(o_cs_n), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rx", 32'(o_data_rx), 32'd0);
    rst_n = 1'b1;

    // Mode 0 loopback, 0xA5.
    c = mk(32'hA5, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    launch(c); wait_done("mode0_done");

    // Modes 1..3 with a slave returning 0x3C.
    for (int m = 1; m < 4; m++) begin
      c = mk($urandom, 32'h3C, 8, m[1], m[0], 1'b0, 1'b0);
      launch(c); wait_done("mode_sweep_done");
    end

    // Short transfer: upper tx bits ignored, slave drives ones.
    c = mk(32'hFF13, 32'hFFFF, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(c); wait_done("short_done");

    // Bit order: 0x01 either leads with the one or ends with it.
    c = mk(32'h01, 0, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    launch(c); wait_done("lsb_done");

    // Length 0 and out-of-range length both mean full width.
    c = mk($urandom, $urandom, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    launch(c); wait_done("len0_done");
    c = mk($urandom, $urandom, 20, 1'b0, 1'b1, 1'b0, 1'b0);
    launch(c); wait_done("len20_done");

    // Start held high: two transfers, the second accepted in the done cycle.
    c = mk(32'h6C, 32'h93, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(c);
    c2 = c;
    c2.b2b = 1'b1;
    push(c);
    push(c2);
    start = 1'b1;
    wait_done("held_first_done");
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept_busy", 32'(o_busy), 32'd1);
    wait_done("held_second_done");

    // Start pulse mid-shift is dropped.
    c = mk($urandom, $urandom, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    launch(c);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midshift_done");
    repeat (LIMIT / 2) @(negedge clk);
    chk("ignored_start_pending", 32'(exp_q.size()), 32'd0);

    // Reset after SCLK edge 5.
    c = mk(32'h5A, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    launch(c); wait_done("pre_reset_done");
    @(negedge clk);
    chk("rx_before_reset", 32'(o_data_rx), 32'h5A);
    c = mk($urandom, 32'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    launch(c);
    k = 0;
    while (s_edges < 6 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("reach_edge5", 32'(s_edges >= 6), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(o_cs_n), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_sclk", 32'(o_sclk), 32'd0);
    chk("abort_rx", 32'(o_data_rx), 32'd0);
    chk("abort_mosi", 32'(o_mosi), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(o_done), 32'd0);
    end
    exp_q.delete();
    res_q.delete();
    cfg_q.delete();
    rst_n = 1'b1;
    c = mk($urandom, $urandom, 12, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(c); wait_done("post_reset_done");

    // Randomised transfers.
    for (int t = 0; t < 20; t++) begin
      c = mk($urandom, $urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      launch(c);
      wait_done("random_done");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("pending_xfers", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised SPI transfer engine that serialises a parallel word onto MOSI and deserialises MISO into a parallel word. It generates SCLK with a divider and handles chip select and start/done handshaking. It supports per-transfer length, clock polarity and clock phase (all four SPI modes). It sits between the SPI master's register/control logic and the pads, and replaces the plain load/shift register with a self-timed transfer unit.

## Interface
- WIDTH, 32, maximum transfer length in bits (>= 2)
- CLK_DIV, 4, i_clk cycles per SCLK half-period (>= 1)
- LW, $clog2(WIDTH+1), width of i_len (derived; not overridden)

- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  transfer request; accepted only in IDLE
- i_data_tx  in  WIDTH  word to transmit, sampled on accept
- i_len  in  LW  bits to transfer; 0 or > WIDTH means WIDTH; sampled on accept
- i_cpol  in  1  SCLK idle level
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- i_lsb_first  in  1  bit order (see Configuration)
- i_miso  in  1  serial input
- o_sclk  out  1  SPI clock
- o_mosi  out  1  serial output
- o_cs_n  out  1  chip select, active low
- o_busy  out  1  high from the cycle after accept through the done cycle, exclusive
- o_done  out  1  one-cycle pulse at transfer end
- o_data_rx  out  WIDTH  received word, right-aligned, valid from the o_done cycle until the next done

## Operation
- Reset values: o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_done=0, o_data_rx=0, state IDLE, counters 0.
- The state machine has four states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - o_sclk follows i_cpol, registered every cycle.
  - o_cs_n=1.
  - On i_start, latch tx, len, cpol, cpha and bit order, then go to SETUP.
- SETUP:
  - o_cs_n=0.
  - o_mosi drives the first tx bit: bit len-1 for MSB-first, bit 0 for LSB-first.
  - Lasts one half-period, then go to SHIFT.
- SHIFT:
  - Each half-period tick toggles o_sclk. There are exactly 2*len edges, numbered 0..2*len-1. Even-numbered edges are leading, odd-numbered edges are trailing.
  - CPHA=0: sample i_miso on leading edges. Advance o_mosi to the next bit on trailing edges, except the last trailing edge.
  - CPHA=1: advance o_mosi on leading edges, except edge 0. Sample i_miso on trailing edges.
  - After edge 2*len-1, go to HOLD. o_sclk is back at cpol.
- HOLD:
  - One half-period with o_cs_n=0 and o_sclk=cpol.
  - At the end: o_cs_n=1, o_busy=0, o_done=1 for one cycle, o_data_rx updated, then IDLE.
- Rx alignment: the first received bit lands at bit len-1 (MSB-first) or bit 0 (LSB-first). Bits >= len are 0.
- Tx bits >= len are ignored.
- o_mosi holds its last driven value after the transfer and in IDLE.
- i_start while busy (SETUP/SHIFT/HOLD) is ignored, with no queueing.
- i_start asserted in the done cycle is accepted; the next transfer begins in the following cycle.
- Input changes on i_cpol/i_cpha/i_len/i_data_tx mid-transfer have no effect.
- Reset asserted mid-transfer returns all outputs to reset values immediately, asynchronously. No done pulse is produced and o_data_rx is cleared.

## Timing
- Accept at cycle T (state IDLE, i_start=1). o_cs_n falls and o_busy rises at T+1.
- SCLK edge k occurs at cycle T+1+CLK_DIV*(k+1), for k = 0..2*len-1.
- Sampling uses the i_miso value registered on the same i_clk edge that toggles o_sclk.
- o_done, o_cs_n rise and o_busy fall all occur at T+1+CLK_DIV*(2*len+1).
- Back-to-back throughput is one transfer per CLK_DIV*(2*len+1)+1 cycles.
- The divider counter is 0..CLK_DIV-1 and is held at 0 in IDLE.

## Configuration
- SPI_SHIFT_LSB_FIRST_EN:
  - Defined: i_lsb_first selects the bit order per transfer.
  - Undefined: i_lsb_first is ignored, every transfer is MSB-first, and the LSB-first logic is not synthesised.

## Test plan
- Mode 0, MSB-first: WIDTH=8, CLK_DIV=2, len=8, tx=0xA5, MISO loopback.
  - MOSI sequence 1,0,1,0,0,1,0,1.
  - rx=0xA5.
  - Done at T+35.
  - o_sclk idles 0.
- Modes 1-3: cpol/cpha sweep with a slave model shifting out 0x3C.
  - rx=0x3C in each mode.
  - o_sclk idle level equals cpol before and after the transfer.
  - Exactly 16 SCLK edges.
- Short length: len=5, tx=0xFF13, slave drives 1s.
  - MOSI is 1,0,0,1,1.
  - rx=0x001F.
  - 10 edges.
  - Done at T+1+2*11.
- LSB-first (macro defined): tx=0x01, len=8.
  - MOSI is 1 then seven 0s.
  - Loopback rx=0x01.
  - With the macro undefined, the same stimulus gives MOSI 0,...,0,1.
- Handshake:
  - i_start held high across the whole transfer gives one transfer plus an immediate second transfer accepted in the done cycle.
  - A start pulse mid-SHIFT is ignored.
  - len=0 yields an 8-bit transfer.
- Reset mid-SHIFT (edge 5):
  - o_cs_n=1, o_busy=0, o_sclk=0 and o_data_rx=0 in the same cycle.
  - No o_done pulse.
  - A following start completes normally.
